alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator-side controller for the 16-bit ALU, which is itself a pure opcode responder. It accepts queued operation commands over a valid/ready interface and drives the ALU's operand, accumulator and opcode inputs. It waits a fixed settle time, captures the ALU output, and returns each result over a valid/ready interface. It also owns the accumulator register and applies the ALU's clear request.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
SETTLE_CYCLES, 1, cycles each command is held on the ALU inputs before capture (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !full, registered-state only, no path from cmd_valid
cmd_opcode  input  6  ALU opcode 0..24
cmd_a  input  16  operand A
cmd_b  input  16  operand B
alu_opcode  output  6  opcode to ALU
alu_a  output  16  operand A to ALU
alu_b  output  16  operand B to ALU
alu_acc  output  16  accumulator value to ALU
alu_out  input  32  ALU result (combinational)
alu_clear  input  1  ALU clear request (ALU reset output)
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  32  captured result
res_err  output  1  illegal opcode flag for this result
res_wide  output  1  alu_out[31:16] nonzero at capture
acc  output  16  current accumulator
busy  output  1  state != IDLE or FIFO non-empty
cmd_count  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset, asynchronous: FIFO emptied, cmd_count=0, state=IDLE, acc=0, alu_a/alu_b/alu_opcode=0, res_valid=0, res_data=0, res_err=0, res_wide=0, settle counter=0.
- Push: the FIFO writes an entry on any edge with cmd_valid && cmd_ready. Entries are {opcode, a, b}, 38 bits.
- alu_acc is continuously equal to acc.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, FIFO non-empty: pop the head at this edge.
  - Opcode <=24: load alu_opcode/alu_a/alu_b, clear the settle counter, go to ISSUE.
  - Opcode 25..63: do not issue to the ALU. Set res_data=0, res_err=1, res_wide=0, res_valid=1, leave acc unchanged, go to RESP.
- ISSUE: alu_* and acc are held stable. The settle counter increments each cycle. On the edge where counter==SETTLE_CYCLES-1, capture in one edge:
  - res_data=alu_out, res_err=0, res_wide=|alu_out[31:16], res_valid=1.
  - acc = alu_clear ? 0 : alu_out[15:0].
  - Go to RESP.
  - alu_clear is ignored outside this capture edge.
- Opcode 0 (clear): the ALU drives alu_clear=1 and alu_out=0, so acc becomes 0 and res_data becomes 0. This is a normal, non-error result.
- RESP: hold res_valid/res_data/res_err/res_wide until res_valid && res_ready. On that edge drop res_valid and go to IDLE. The next pop can occur on the following edge at the earliest (one idle cycle between commands).
- Latency with SETTLE_CYCLES=1: push at edge E, pop at E+1, res_valid high after E+2. In general, res_valid rises at pop+SETTLE_CYCLES.
- Pipelining: strictly one command in flight. Pushes continue during ISSUE/RESP until the FIFO is full.
- Full FIFO: cmd_ready=0. Push and pop on the same edge are legal when not full; cmd_count is then unchanged.
- Empty FIFO in IDLE: remain in IDLE; alu_* hold their last values.
- Wide results (opcodes 4,5,8,16,17,20): res_data carries all 32 bits; acc takes the low 16 bits only (truncation).
- Wrap-around: FIFO pointers wrap modulo DEPTH. Occupancy is tracked separately so full and empty are distinguished.
- Reset mid-operation (any state): everything returns to reset values immediately. In-flight and queued commands are discarded, and no result is produced.

Test Plan:
- Reset, then push {6,3,2}. Expect res_data=5, acc=5, res_err=0 two cycles after the push (SETTLE=1).
- Push {18,x,2} with acc=5. Expect res_data=7, acc=7. Then push {0,0,0}: expect res_data=0, acc=0, res_err=0.
- Push {8,16'h0100,16'h0100}. Expect res_data=32'h00010000, res_wide=1, acc=16'h0000.
- Push {30,1,1}. Expect res_err=1, res_data=0, acc unchanged, and alu_opcode unchanged from its prior value.
- Hold res_ready=0 and push DEPTH+1 commands. Expect cmd_ready=0 once cmd_count==DEPTH. Release res_ready: all results arrive in order with no drops.
- Assert reset while in ISSUE with 2 commands queued. Expect busy=0, cmd_count=0, res_valid=0, acc=0 asynchronously, and no further results.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit ALU: queues operations, drives the ALU,
// waits a settle time, captures the result and owns the accumulator.
module alu_cmd_sequencer #(
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [5:0]                 cmd_opcode,
   input  logic [15:0]                cmd_a,
   input  logic [15:0]                cmd_b,
   output logic [5:0]                 alu_opcode,
   output logic [15:0]                alu_a,
   output logic [15:0]                alu_b,
   output logic [15:0]                alu_acc,
   input  logic [31:0]                alu_out,
   input  logic                       alu_clear,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [31:0]                res_data,
   output logic                       res_err,
   output logic                       res_wide,
   output logic [15:0]                acc,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] cmd_count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNTW-1:0] FULL_CNT    = CNTW'(DEPTH);
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t          state, state_nxt;
   logic [37:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [37:0]     head;
   logic [SW-1:0]   settle_cnt;
   logic            push, pop, capture, head_legal;

   assign cmd_ready  = (cmd_count != FULL_CNT);
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && (cmd_count != '0);
   assign head       = mem[rd_ptr];
   assign head_legal = (head[37:32] <= 6'd24);
   assign capture    = (state == ISSUE) && (settle_cnt == SETTLE_LAST);
   assign alu_acc    = acc;
   assign busy       = (state != IDLE) || (cmd_count != '0);

   // Storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cmd_count <= cmd_count + 1'b1;
            2'b01:   cmd_count <= cmd_count - 1'b1;
            default: cmd_count <= cmd_count;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = head_legal ? ISSUE : RESP;
         ISSUE:   if (capture) state_nxt = RESP;
         RESP:    if (res_valid && res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         acc        <= '0;
         settle_cnt <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_err    <= 1'b0;
         res_wide   <= 1'b0;
      end else begin
         if (pop) begin
            if (head_legal) begin
               alu_opcode <= head[37:32];
               alu_a      <= head[31:16];
               alu_b      <= head[15:0];
               settle_cnt <= '0;
            end else begin
               // Illegal opcodes never reach the ALU; answer immediately.
               res_data  <= '0;
               res_err   <= 1'b1;
               res_wide  <= 1'b0;
               res_valid <= 1'b1;
            end
         end
         if (state == ISSUE)
            settle_cnt <= settle_cnt + 1'b1;
         if (capture) begin
            res_data  <= alu_out;
            res_err   <= 1'b0;
            res_wide  <= |alu_out[31:16];
            res_valid <= 1'b1;
            acc       <= alu_clear ? '0 : alu_out[15:0];
         end
         if (state == RESP && res_valid && res_ready)
            res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

   localparam int DEPTH  = 4;
   localparam int SETTLE = 1;

   logic        clock, reset;
   logic        cmd_valid, cmd_ready;
   logic [5:0]  cmd_opcode;
   logic [15:0] cmd_a, cmd_b;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_a, alu_b, alu_acc;
   logic [31:0] alu_out;
   logic        alu_clear;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic        res_err, res_wide;
   logic [15:0] acc;
   logic        busy;
   logic [$clog2(DEPTH+1)-1:0] cmd_count;

   int compared   = 0;
   int mismatched = 0;
   bit rnd_en     = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        wide;
      logic [15:0] acc;
      logic [5:0]  op;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] m_acc;
   logic [5:0]  m_last_op;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_acc(alu_acc),
      .alu_out(alu_out), .alu_clear(alu_clear),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err), .res_wide(res_wide),
      .acc(acc), .busy(busy), .cmd_count(cmd_count)
   );

   // Behavioural ALU: returns {clear, out}. Wide ops are 4,5,8,16,17,20.
   function automatic logic [32:0] alu_fn(input logic [5:0] op,
                                          input logic [15:0] a, b, ac);
      logic [15:0] t;
      logic [31:0] w;
      logic        wide_op;
      t = '0; w = '0; wide_op = 1'b0;
      case (op)
         6'd1:  t = a & b;
         6'd2:  t = a | b;
         6'd3:  t = a ^ b;
         6'd4:  begin wide_op = 1; w = {16'h0, a} * {16'h0, b}; end
         6'd5:  begin wide_op = 1; w = {16'h0, ac} * {16'h0, b}; end
         6'd6:  t = a + b;
         6'd7:  t = a - b;
         6'd8:  begin wide_op = 1; w = {16'h0, a} * {16'h0, b}; end
         6'd9:  t = ~a;
         6'd10: t = a << 1;
         6'd11: t = a >> 1;
         6'd12: t = ac + a;
         6'd13: t = ac - a;
         6'd14: t = ac & b;
         6'd15: t = ac | b;
         6'd16: begin wide_op = 1; w = {a, b}; end
         6'd17: begin wide_op = 1; w = {b, a}; end
         6'd18: t = ac + b;
         6'd19: t = ac ^ b;
         6'd20: begin wide_op = 1; w = {16'h0, ac} * {16'h0, a}; end
         6'd21: t = (a == b) ? 16'd1 : 16'd0;
         6'd22: t = (a < b) ? 16'd1 : 16'd0;
         6'd23: t = b;
         6'd24: t = ac;
         default: t = '0;
      endcase
      if (op == 6'd0) return {1'b1, 32'h0};
      return wide_op ? {1'b0, w} : {1'b0, 16'h0, t};
   endfunction

   always_comb begin
      {alu_clear, alu_out} = alu_fn(alu_opcode, alu_a, alu_b, alu_acc);
   end

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: commands complete strictly in push order, so the expected
   // result of each one is fixed at the moment it is accepted.
   task automatic model_push(input logic [5:0] op, input logic [15:0] a, b);
      exp_t        e;
      logic [32:0] r;
      if (op <= 6'd24) begin
         r         = alu_fn(op, a, b, m_acc);
         e.data    = r[31:0];
         e.err     = 1'b0;
         e.wide    = (r[31:16] != 16'h0);
         m_acc     = r[32] ? 16'h0 : r[15:0];
         m_last_op = op;
      end else begin
         e.data = '0;
         e.err  = 1'b1;
         e.wide = 1'b0;
      end
      e.acc = m_acc;
      e.op  = m_last_op;
      sbq.push_back(e);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         sbq.delete();
         m_acc     = '0;
         m_last_op = '0;
      end else begin
         if (cmd_valid && cmd_ready)
            model_push(cmd_opcode, cmd_a, cmd_b);
         if (res_valid && res_ready) begin
            compared++;
            if (sbq.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_result: got data=%h err=%b with nothing outstanding",
                        res_data, res_err);
            end else begin
               e = sbq.pop_front();
               if ({res_data, res_err, res_wide, acc, alu_opcode} !==
                   {e.data, e.err, e.wide, e.acc, e.op}) begin
                  mismatched++;
                  $display("FAIL result: got data=%h err=%b wide=%b acc=%h op=%0d, expected data=%h err=%b wide=%b acc=%h op=%0d",
                           res_data, res_err, res_wide, acc, alu_opcode,
                           e.data, e.err, e.wide, e.acc, e.op);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (rnd_en) res_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic push_cmd(input logic [5:0] op, input logic [15:0] a, b);
      bit got;
      got        = 0;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_valid  = 1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         if (cmd_ready) begin
            got = 1;
            break;
         end
         tick();
      end
      if (got) tick();
      cmd_valid = 0;
      check("push_accepted", {31'h0, got}, 32'h1);
   endtask

   task automatic wait_res();
      bit got;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (res_valid) begin
            got = 1;
            break;
         end
      end
      check("res_valid_timeout", {31'h0, got}, 32'h1);
   endtask

   task automatic release_res();
      tick();
      res_ready = 1;
      tick();
      res_ready = 0;
   endtask

   task automatic do_cmd(input string name, input logic [5:0] op, input logic [15:0] a, b,
                         input logic [31:0] e_data, input logic [15:0] e_acc,
                         input logic e_err, input logic e_wide, input logic [5:0] e_op);
      push_cmd(op, a, b);
      wait_res();
      check({name, "_data"}, res_data, e_data);
      check({name, "_acc"}, {16'h0, acc}, {16'h0, e_acc});
      check({name, "_flags"}, {30'h0, res_err, res_wide}, {30'h0, e_err, e_wide});
      check({name, "_opcode"}, {26'h0, alu_opcode}, {26'h0, e_op});
      release_res();
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int i = 0; i < 3000; i++) begin
         if (sbq.size() == 0 && !busy) begin
            done = 1;
            break;
         end
         tick();
      end
      check("drain", {31'h0, done}, 32'h1);
   endtask

   initial begin
      bit seen;
      reset = 1; cmd_valid = 0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; res_ready = 0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_res_valid", {31'h0, res_valid}, 32'h0);
      check("rst_count", {29'h0, cmd_count}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_acc", {16'h0, acc}, 32'h0);
      check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      check("rst_alu", {alu_opcode[3:0], alu_a, 12'h0}, 32'h0);
      reset = 0;
      tick();

      // First command: latency and value
      push_cmd(6'd6, 16'd3, 16'd2);
      check("lat_after_push", {31'h0, res_valid}, 32'h0);
      tick();
      check("lat_after_pop", {31'h0, res_valid}, 32'h0);
      tick();
      check("lat_capture", {31'h0, res_valid}, 32'h1);
      check("add_data", res_data, 32'd5);
      check("add_acc", {16'h0, acc}, 32'd5);
      check("add_err", {31'h0, res_err}, 32'h0);
      release_res();

      do_cmd("accb", 6'd18, 16'($urandom), 16'd2, 32'd7, 16'd7, 1'b0, 1'b0, 6'd18);
      do_cmd("clear", 6'd0, 16'd0, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0, 6'd0);
      do_cmd("wide", 6'd8, 16'h0100, 16'h0100, 32'h00010000, 16'h0000, 1'b0, 1'b1, 6'd8);
      do_cmd("illegal", 6'd30, 16'd1, 16'd1, 32'd0, 16'h0000, 1'b1, 1'b0, 6'd8);

      // Fill the FIFO while the consumer stalls
      for (int unsigned i = 0; i < DEPTH + 1; i++)
         push_cmd(6'($urandom_range(1, 24)), 16'($urandom), 16'($urandom));
      check("full_count", {29'h0, cmd_count}, DEPTH);
      check("full_ready", {31'h0, cmd_ready}, 32'h0);
      cmd_opcode = 6'd23; cmd_a = 16'h5555; cmd_b = 16'haaaa; cmd_valid = 1;
      repeat (4) tick();
      check("full_hold_ready", {31'h0, cmd_ready}, 32'h0);
      check("full_hold_count", {29'h0, cmd_count}, DEPTH);
      cmd_valid = 0;
      res_ready = 1;
      drain();
      res_ready = 0;

      // Randomised traffic with back-pressure
      rnd_en = 1;
      for (int i = 0; i < 200; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(25, 63)) : 6'($urandom_range(0, 24));
         push_cmd(op, 16'($urandom), 16'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      rnd_en = 0;
      res_ready = 1;
      drain();
      res_ready = 0;
      tick();

      // Reset while a command is in ISSUE with two more queued
      push_cmd(6'd23, 16'd0, 16'h1234);
      wait_res();
      check("pre_rst_acc", {16'h0, acc}, 32'h1234);
      tick();
      for (int i = 0; i < 3; i++)
         push_cmd(6'($urandom_range(1, 24)), 16'($urandom), 16'($urandom));
      res_ready = 1;
      tick();
      res_ready = 0;
      tick();
      check("issue_count", {29'h0, cmd_count}, 32'd2);
      check("issue_busy", {31'h0, busy}, 32'h1);
      #1 reset = 1;
      #1;
      check("arst_busy", {31'h0, busy}, 32'h0);
      check("arst_count", {29'h0, cmd_count}, 32'h0);
      check("arst_res_valid", {31'h0, res_valid}, 32'h0);
      check("arst_acc", {16'h0, acc}, 32'h0);
      @(negedge clock);
      #1 reset = 0;
      res_ready = 1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (res_valid) seen = 1;
      end
      check("no_result_after_reset", {31'h0, seen}, 32'h0);
      check("idle_after_reset", {31'h0, busy}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
